// File: rtl/i2c_regmap_bridge.sv
// Clock-domain register file behind an SCL-clocked I2C slave: synchronizes the slave's
// regmap strobe/bus, commits control writes, serves reads. Option: I2C_REGMAP_SNAPSHOT_EN.
module i2c_regmap_bridge #(
  parameter int NUM_REGS    = 16,
  parameter int RO_BASE     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      i2c_addr,
  input  logic [7:0]                      i2c_wdata,
  input  logic                            i2c_wr_pulse,
  input  logic                            i2c_active,
  output logic [7:0]                      i2c_rdata,
  output logic [8*RO_BASE-1:0]            ctrl_regs,
  input  logic [8*(NUM_REGS-RO_BASE)-1:0] status_in,
  output logic                            reg_wr_strobe,
  output logic [7:0]                      reg_wr_addr,
  output logic                            err_flag,
  input  logic                            err_clr
);
  localparam int         NUM_STAT = NUM_REGS - RO_BASE;
  localparam logic [8:0] RO_LIM   = 9'(RO_BASE);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_HOLD} wstate_t;
  wstate_t state, state_nxt;

  logic [SYNC_STAGES-1:0] wr_sync, act_sync;
  logic [7:0]             addr_sync  [SYNC_STAGES];
  logic [7:0]             wdata_sync [SYNC_STAGES];
  logic                   wr_p1, act_p1;
  logic [7:0]             addr_p1, wdata_p1, addr_q, wdata_q;
  logic                   wr_p0, act_p0, wr_rise, act_rise;
  logic [7:0]             addr_p0, wdata_p0;
  logic                   addr_ok, wdata_ok;
  logic                   commit_wr, commit_err;
  logic [7:0]             rdata_nxt;
  logic [8*NUM_STAT-1:0]  stat_src;

  assign wr_p0    = wr_sync[SYNC_STAGES-1];
  assign act_p0   = act_sync[SYNC_STAGES-1];
  assign addr_p0  = addr_sync[SYNC_STAGES-1];
  assign wdata_p0 = wdata_sync[SYNC_STAGES-1];
  assign wr_rise  = wr_p0 & ~wr_p1;
  assign act_rise = act_p0 & ~act_p1;
  // A multi-bit value is trusted only once two consecutive synced samples agree
  assign addr_ok  = (addr_p0 == addr_p1);
  assign wdata_ok = (wdata_p0 == wdata_p1);

  // Stage: synchronizers, edge-detect history, stable-qualified bus capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync  <= '0;
      act_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync[i]  <= '0;
        wdata_sync[i] <= '0;
      end
      wr_p1    <= 1'b0;
      act_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_sync       <= {wr_sync[SYNC_STAGES-2:0], i2c_wr_pulse};
      act_sync      <= {act_sync[SYNC_STAGES-2:0], i2c_active};
      addr_sync[0]  <= i2c_addr;
      wdata_sync[0] <= i2c_wdata;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync[i]  <= addr_sync[i-1];
        wdata_sync[i] <= wdata_sync[i-1];
      end
      wr_p1    <= wr_p0;
      act_p1   <= act_p0;
      addr_p1  <= addr_p0;
      wdata_p1 <= wdata_p0;
      if (addr_ok)  addr_q  <= addr_p0;
      if (wdata_ok) wdata_q <= wdata_p0;
    end
  end

  always_comb begin
    state_nxt  = state;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state)
      W_IDLE:   if (wr_rise) state_nxt = W_COMMIT;
      W_COMMIT: begin
        // Anything at or above RO_BASE (status or out of range) is an illegal write
        if ({1'b0, addr_q} < RO_LIM) commit_wr  = 1'b1;
        else                         commit_err = 1'b1;
        state_nxt = W_HOLD;
      end
      W_HOLD:   if (!wr_p0) state_nxt = W_IDLE;
      default:  state_nxt = W_IDLE;
    endcase
  end

  // Stage: write commit and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= W_IDLE;
      ctrl_regs     <= '0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      err_flag      <= 1'b0;
    end else begin
      state         <= state_nxt;
      reg_wr_strobe <= commit_wr;
      if (commit_wr) reg_wr_addr <= addr_q;
      for (int k = 0; k < RO_BASE; k++)
        if (commit_wr && addr_q == 8'(k)) ctrl_regs[8*k +: 8] <= wdata_q;
      if (commit_err)   err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

`ifdef I2C_REGMAP_SNAPSHOT_EN
  logic [8*NUM_STAT-1:0] shadow;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           shadow <= '0;
    else if (act_rise) shadow <= status_in;
  end
  assign stat_src = shadow;
`else
  logic unused_act;
  assign unused_act = act_rise;
  assign stat_src   = status_in;
`endif

  always_comb begin
    rdata_nxt = 8'hFF;
    for (int k = 0; k < RO_BASE; k++)
      if (addr_p0 == 8'(k)) rdata_nxt = ctrl_regs[8*k +: 8];
    for (int j = 0; j < NUM_STAT; j++)
      if ({1'b0, addr_p0} == 9'(RO_BASE + j)) rdata_nxt = stat_src[8*j +: 8];
  end

  // Stage: registered read data, held while the address is unsettled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          i2c_rdata <= 8'hFF;
    else if (addr_ok) i2c_rdata <= rdata_nxt;
  end
endmodule

// File: doc/i2c_regmap_bridge.md
Name: i2c_regmap_bridge

Overview:
System-clock register file that sits directly downstream of the SCL-clocked I2C slave. It consumes the slave's regmap outputs (addr, wdata, wr_en_wdata) and drives the slave's rdata input. It brings the SCL-domain write strobe and address into the clk domain, commits writes to control registers, and serves control or status bytes for reads. It also flags illegal accesses.

Parameters:
NUM_REGS, 16, total register count; valid addresses are 0..NUM_REGS-1 (NUM_REGS ≤ 256).
RO_BASE, 8, addresses ≥ RO_BASE are read-only status registers; addresses < RO_BASE are R/W control registers (1 ≤ RO_BASE < NUM_REGS).
SYNC_STAGES, 2, flop count of each CDC synchronizer (≥ 2).

Ports:
clk  in  1  system clock; f_clk ≥ 8×f_SCL required.
rst  in  1  asynchronous, active-high reset.
i2c_addr  in  8  slave addr; SCL domain, quasi-static.
i2c_wdata  in  8  slave wdata; SCL domain, quasi-static.
i2c_wr_pulse  in  1  slave wr_en_wdata; one SCL period high.
i2c_active  in  1  slave i2c_active; asynchronous.
i2c_rdata  out  8  to slave rdata; registered in clk domain.
ctrl_regs  out  8*RO_BASE  control registers; byte k at bits [8k+7:8k].
status_in  in  8*(NUM_REGS-RO_BASE)  status bytes; byte j maps to address RO_BASE+j.
reg_wr_strobe  out  1  one-clk pulse on each committed control write.
reg_wr_addr  out  8  address of the last committed write.
err_flag  out  1  sticky illegal-access flag.
err_clr  in  1  clears err_flag.

Behaviour:
- Reset values: ctrl_regs=0, i2c_rdata=8'hFF, reg_wr_strobe=0, reg_wr_addr=0, err_flag=0, write FSM=W_IDLE, all synchronizer flops=0.
- i2c_wr_pulse, i2c_active: each passes through a SYNC_STAGES synchronizer followed by a registered rising-edge detector.
- i2c_addr, i2c_wdata: each passes through a SYNC_STAGES bus synchronizer. The synced value is accepted only when two consecutive clk samples are equal (stable-qualified).
- Write FSM:
  - W_IDLE: a wr_pulse rise moves to W_COMMIT.
  - W_COMMIT: one cycle. Latch the stable addr/wdata.
    - If addr < RO_BASE: ctrl_regs[addr] <= wdata, reg_wr_strobe=1 for this cycle, reg_wr_addr <= addr.
    - If RO_BASE ≤ addr < NUM_REGS: write dropped, err_flag <= 1.
    - If addr ≥ NUM_REGS: write dropped, err_flag <= 1.
    - Next state: W_HOLD.
  - W_HOLD: wait until synced wr_pulse = 0, then go to W_IDLE. Each SCL pulse therefore yields exactly one commit.
- Commit latency: SYNC_STAGES+2 clk cycles from the i2c_wr_pulse rise to reg_wr_strobe.
- Read path: i2c_rdata is updated every clk from the stable addr.
  - addr < RO_BASE: ctrl_regs byte.
  - RO_BASE ≤ addr < NUM_REGS: status byte.
  - addr ≥ NUM_REGS: 8'hFF.
  - If the stable-qualify check fails in a cycle, i2c_rdata holds its previous value.
  - Read-after-write: a read of a just-written address returns the new value once the commit completes. No bypass.
- err_flag: set by a dropped write; cleared by err_clr. If set and clear coincide, set wins. Reads of invalid addresses do not set err_flag.
- i2c_active falling mid-byte: no effect on the FSM. A pulse already in W_COMMIT completes.
- rst mid-operation: everything returns to reset values immediately. A pending write is lost.

Optional Feature:
Macro: I2C_REGMAP_SNAPSHOT_EN
- With macro: on the synced i2c_active rise, status_in is captured into a shadow array. Reads of status addresses return the shadow, so multi-byte reads are coherent for the whole transaction. The shadow resets to 0.
- Without macro: status reads return live status_in. No shadow flops are generated.

Test Plan:
- Reset: assert rst -> i2c_rdata=8'hFF, ctrl_regs=0, err_flag=0, reg_wr_strobe=0.
- Single write: addr=8'h03, wdata=8'hA5, wr_pulse for one SCL period -> exactly one reg_wr_strobe, SYNC_STAGES+2 clks after the pulse rise; ctrl_regs byte3=8'hA5; reg_wr_addr=8'h03.
- Auto-increment burst: writes 8'h11, 8'h22, 8'h33 to addr 0,1,2 -> three strobes; bytes 0..2 = 11/22/33; other bytes 0.
- Illegal writes: write 8'h5A to addr 8'h09, then to addr 8'h20 -> no strobe, ctrl_regs unchanged, err_flag=1. err_clr pulse -> err_flag=0. err_clr coinciding with a new illegal write -> err_flag stays 1.
- Reads: status_in byte1=8'hC3, addr=8'h09 -> i2c_rdata=8'hC3. addr=8'h03 after the earlier write -> 8'hA5. addr=8'hF0 -> 8'hFF.
- Snapshot (macro on): status byte0=8'h10 at i2c_active rise, changed to 8'h20 mid-transaction -> read of addr 8'h08 returns 8'h10. Macro off -> 8'h20.
